mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: busy length of mult/multu, in cycles.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: busy length of div/divu, in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port start, input, 1 bit: launches the operation in op for one cycle.
REQ-006 SHALL have port op, input, 3 bits: 0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo, 6-7 = no-op.
REQ-007 SHALL have port A, input, 32 bits: rs operand (dividend, or multiplicand, or mthi/mtlo source).
REQ-008 SHALL have port B, input, 32 bits: rt operand (divisor or multiplier).
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-010 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 SHALL have exactly 2 states: IDLE and RUN, plus a cycle counter of at least 4 bits.
REQ-013 In IDLE, with start=1 and op in 0-3, the unit SHALL latch A, B and op on the edge, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 busy SHALL equal 1 exactly while in RUN: N consecutive cycles after the launch edge, where N is the op's cycle count.
REQ-015 In RUN, the counter SHALL decrement each edge; on the edge where it reaches zero, HI/LO SHALL take the result, busy SHALL drop to 0 and the state SHALL return to IDLE.
REQ-016 HI/LO SHALL NOT change before the commit edge, so mfhi/mflo during busy reads the old values.
REQ-017 mult SHALL form the signed 64-bit product {HI,LO} = $signed(A)*$signed(B).
REQ-018 multu SHALL form the unsigned 64-bit product.
REQ-019 div SHALL give LO = signed quotient truncated toward zero and HI = remainder, which takes the sign of the dividend.
REQ-020 divu SHALL give the unsigned quotient in LO and the unsigned remainder in HI.
REQ-021 div/divu with B=0 SHALL still run DIV_CYCLES with busy=1, then leave HI and LO unchanged.
REQ-022 div with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 mthi/mtlo with start=1 in IDLE SHALL write A into HI/LO on that edge, with busy staying 0 and no RUN entry.
REQ-024 start=1 while busy=1 SHALL be ignored: no operand latch, no HI/LO write, the count is unaffected.
REQ-025 When the commit edge coincides with start=1, start SHALL be ignored.
REQ-026 start with op 6-7 SHALL have no effect.
REQ-027 Results SHALL depend only on operands latched at launch; A/B changes during RUN SHALL have no effect.

Reset
REQ-028 On reset=1 at a clk edge, HI=0, LO=0, busy=0, state=IDLE and counter=0, overriding start.
REQ-029 Reset during RUN SHALL abort the operation with no commit.
REQ-030 Power-up (initial) values SHALL equal the reset values.

Verification
REQ-031 A bench SHALL cover mult with A=0xFFFFFFFD, B=5 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-032 A bench SHALL cover multu with A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 A bench SHALL cover div with A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; HI/LO hold old values during busy.
REQ-034 A bench SHALL cover divu with A=7, B=0 after mthi 0x1234 / mtlo 0x5678 -> busy high for 10 cycles, then HI=0x1234, LO=0x5678.
REQ-035 A bench SHALL cover mult 3*4 then, 2 cycles later, start div 9/2 -> div ignored; after 5 cycles HI=0, LO=12.
REQ-036 A bench SHALL cover divu 100/7 with reset pulsed in cycle 4 -> busy=0, HI=0, LO=0 next cycle; no later commit.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with architectural HI/LO registers.
// Launching a mult/div latches the operands and holds busy for a fixed number of
// cycles. HI/LO change only on the final (commit) edge, so mfhi/mflo issued while
// busy still see the previous results. mthi/mtlo write HI/LO immediately when idle.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Encoding of the op input.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Only the multi-cycle ops are latched, so two bits identify them.
  localparam logic [1:0] LOP_MULT  = 2'd0;
  localparam logic [1:0] LOP_MULTU = 2'd1;
  localparam logic [1:0] LOP_DIV   = 2'd2;
  localparam logic [1:0] LOP_DIVU  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Initializers match the reset values so power-up and reset states agree.
  state_t           state_r = ST_IDLE;
  logic [CNT_W-1:0] cnt_r   = CNT_W'(0);
  logic             busy_r  = 1'b0;
  logic [31:0]      hi_r    = 32'd0;
  logic [31:0]      lo_r    = 32'd0;
  logic [31:0]      a_r     = 32'd0;
  logic [31:0]      b_r     = 32'd0;
  logic [1:0]       op_r    = 2'd0;

  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] num_s;
  logic [31:0] den_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;
  logic        res_we_s;

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

  // Result datapath, driven only by the operands captured at launch.
  always_comb begin
    a_mag_s  = 32'd0;
    b_mag_s  = 32'd0;
    num_s    = 32'd0;
    den_s    = 32'd0;
    q_mag_s  = 32'd0;
    r_mag_s  = 32'd0;
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    res_we_s = 1'b0;

    // Signed divide works on magnitudes, signs are restored afterwards.
    if (a_r[31]) begin
      a_mag_s = 32'd0 - a_r;
    end else begin
      a_mag_s = a_r;
    end
    if (b_r[31]) begin
      b_mag_s = 32'd0 - b_r;
    end else begin
      b_mag_s = b_r;
    end

    if (op_r == LOP_DIV) begin
      num_s = a_mag_s;
      den_s = b_mag_s;
    end else begin
      num_s = a_r;
      den_s = b_r;
    end

    if (den_s != 32'd0) begin
      q_mag_s = num_s / den_s;
      r_mag_s = num_s % den_s;
    end else begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end

    case (op_r)
      LOP_MULT: begin
        // Low 64 bits of the sign-extended product equal the signed product.
        {res_hi_s, res_lo_s} = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
        res_we_s = 1'b1;
      end
      LOP_MULTU: begin
        {res_hi_s, res_lo_s} = {32'd0, a_r} * {32'd0, b_r};
        res_we_s = 1'b1;
      end
      LOP_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        // 0x80000000 / -1 wraps naturally to 0x80000000 with remainder 0.
        if (a_r[31] ^ b_r[31]) begin
          res_lo_s = 32'd0 - q_mag_s;
        end else begin
          res_lo_s = q_mag_s;
        end
        if (a_r[31]) begin
          res_hi_s = 32'd0 - r_mag_s;
        end else begin
          res_hi_s = r_mag_s;
        end
        // Divide by zero leaves HI/LO untouched.
        res_we_s = (den_s != 32'd0);
      end
      LOP_DIVU: begin
        res_lo_s = q_mag_s;
        res_hi_s = r_mag_s;
        res_we_s = (den_s != 32'd0);
      end
      default: begin
        res_we_s = 1'b0;
      end
    endcase
  end

  // Control FSM, cycle counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_r     <= A;
                b_r     <= B;
                op_r    <= op[1:0];
                cnt_r   <= MULT_LOAD;
                busy_r  <= 1'b1;
                state_r <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                a_r     <= A;
                b_r     <= B;
                op_r    <= op[1:0];
                cnt_r   <= DIV_LOAD;
                busy_r  <= 1'b1;
                state_r <= ST_RUN;
              end
              OP_MTHI: begin
                hi_r <= A;
              end
              OP_MTLO: begin
                lo_r <= A;
              end
              default: begin
              end
            endcase
          end
        end
        ST_RUN: begin
          // start is ignored throughout RUN, including the commit edge.
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            if (res_we_s) begin
              hi_r <= res_hi_s;
              lo_r <= res_lo_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a reference model computes HI/LO and the
// expected busy length when an op is launched, pushes them to a scoreboard queue,
// and the entry is popped and compared when the unit finishes.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  // Reference architectural state.
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: updates hi_m/lo_m and returns the busy length.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    logic [63:0] p;
    longint      q;
    longint      r;
    cyc = 0;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        hi_m = p[63:32];
        lo_m = p[31:0];
        cyc = 5;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        hi_m = p[63:32];
        lo_m = p[31:0];
        cyc = 5;
      end
      3'd2: begin
        if (b != 32'd0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          lo_m = q[31:0];
          hi_m = r[31:0];
        end
        cyc = 10;
      end
      3'd3: begin
        if (b != 32'd0) begin
          lo_m = a / b;
          hi_m = a % b;
        end
        cyc = 10;
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: cyc = 0;
    endcase
  endtask

  // Launch one op; optionally assert start again (op intr_op, A=9, B=2) on busy
  // cycle intr_at. Operands are scrambled every busy cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int intr_at, input logic [2:0] intr_op);
    exp_t        e;
    int          cyc;
    int          n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = hi_m;
    old_lo = lo_m;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    model_op(o, a, b, cyc);
    e.hi = hi_m;
    e.lo = lo_m;
    e.cycles = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      chk({tag, "_hold_hi"}, HI, old_hi);
      chk({tag, "_hold_lo"}, LO, old_lo);
      if (n == intr_at) begin
        start = 1'b1;
        op    = intr_op;
        A     = 32'd9;
        B     = 32'd2;
      end else begin
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_cycles"}, n, e.cycles);
    chk({tag, "_hi"}, HI, e.hi);
    chk({tag, "_lo"}, LO, e.lo);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;

    // Power-up values, before any clock edge.
    #1;
    chk("pwrup_busy", busy, 1'b0);
    chk("pwrup_hi", HI, 32'd0);
    chk("pwrup_lo", LO, 32'd0);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 3'd0);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'd2, 0, 3'd0);
    run_op("mthi", 3'd4, 32'h0000_1234, 32'd0, 0, 3'd0);
    run_op("mtlo", 3'd5, 32'h0000_5678, 32'd0, 0, 3'd0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd0);
    run_op("mthi2", 3'd4, 32'h0000_1234, 32'd0, 0, 3'd0);
    run_op("mtlo2", 3'd5, 32'h0000_5678, 32'd0, 0, 3'd0);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 0, 3'd0);
    run_op("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0, 0, 3'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0);
    run_op("mult_busy_start", 3'd0, 32'd3, 32'd4, 2, 3'd2);
    run_op("commit_start", 3'd1, 32'h0001_0001, 32'h0000_0100, 5, 3'd4);
    run_op("div_commit_start", 3'd2, 32'd100, 32'hFFFF_FFF9, 10, 3'd0);
    run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1, 0, 3'd0);
    run_op("nop7", 3'd7, 32'hCAFE_F00D, 32'd1, 0, 3'd0);

    for (int i = 0; i < 16; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 12), 3'($urandom_range(0, 7)));
    end

    // divu 100/7 aborted by reset in its 4th busy cycle.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd3;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", HI, hi_m);
    chk("abort_lo", LO, lo_m);
    repeat (12) @(negedge clk);
    chk("abort_late_busy", busy, 1'b0);
    chk("abort_late_hi", HI, hi_m);
    chk("abort_late_lo", LO, lo_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
